si_tx_arbiter: RTL and testbench

Shares the single SI (joybus) transmitter between two requesters: the hardware auto-responder (port 0, e.g. EEPROM/RTC replies) and the CPU-driven path (port 1). It captures a granted request, loads the 1-3 payload words into the SI TX buffer through the word write-mask strobes, starts transmission, supervises completion with timeouts, and reports done/error to the winner. It sits between the requesters and the SI PHY TX controls.

---
 rtl/si_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_si_tx_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/si_tx_arbiter.sv
// si_tx_arbiter: shares the SI transmitter between the auto-responder (port 0) and the CPU path (port 1),
// loading payload words, starting transmission and supervising completion with timeouts.
module si_tx_arbiter #(
  parameter int HW_PRIORITY = 1,
  parameter int BUSY_WAIT   = 8,
  parameter int TX_TIMEOUT  = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [95:0] req_data0,
  input  logic [95:0] req_data1,
  input  logic [6:0]  req_length0,
  input  logic [6:0]  req_length1,
  output logic [1:0]  req_ack,
  output logic [1:0]  req_done,
  output logic        req_err,
  output logic        busy,
  output logic [31:0] si_tx_data,
  output logic [2:0]  si_tx_wmask,
  output logic [6:0]  si_tx_length,
  output logic        si_tx_start,
  output logic        si_tx_reset,
  input  logic        si_tx_busy
);
  localparam int CW = $clog2((BUSY_WAIT > TX_TIMEOUT ? BUSY_WAIT : TX_TIMEOUT) + 1);
  typedef enum logic [2:0] {IDLE, CHECK, LOAD, START, WAIT_BUSY, WAIT_DONE, ABORT, DONE} state_t;
  state_t state_q, state_d;
  logic [95:0] data_q, data_d;
  logic [6:0] len_q, len_d;
  logic port_q, port_d, last_q, last_d, err_q, err_d;
  logic [1:0] idx_q, idx_d, nw_q, nw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic win;
  logic [7:0] len8;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      port_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      nw_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      port_q  <= port_d;
      last_q  <= last_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      nw_q    <= nw_d;
      cnt_q   <= cnt_d;
    end
  end
  // Round-robin: on a tie the port that was not served last wins.
  always_comb begin
    win  = (HW_PRIORITY != 0) ? !req_valid[0] : (&req_valid ? !last_q : req_valid[1]);
    len8 = {1'b0, len_q};
  end
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    port_d  = port_q;
    last_d  = last_q;
    err_d   = err_q;
    idx_d   = idx_q;
    nw_d    = nw_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d = CHECK;
        port_d  = win;
        last_d  = win;
        data_d  = win ? req_data1 : req_data0;
        len_d   = win ? req_length1 : req_length0;
        err_d   = 1'b0;
        nw_d    = '0;
      end
      CHECK: if (len8 == 8'd0 || len8 > 8'd96) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        nw_d    = 2'((len8 + 8'd31) >> 5);
        idx_d   = '0;
        state_d = LOAD;
      end
      LOAD: if (idx_q == nw_q - 2'd1) state_d = START;
            else idx_d = idx_q + 2'd1;
      // The counter holds cycles elapsed since the reference event (start pulse / busy rise).
      START: begin
        cnt_d   = CW'(1);
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (si_tx_busy) begin
        cnt_d   = CW'(1);
        state_d = WAIT_DONE;
      end else if (cnt_q + CW'(1) >= CW'(BUSY_WAIT)) state_d = ABORT;
      else cnt_d = cnt_q + CW'(1);
      WAIT_DONE: if (!si_tx_busy) state_d = DONE;
      else if (cnt_q + CW'(1) >= CW'(TX_TIMEOUT)) state_d = ABORT;
      else cnt_d = cnt_q + CW'(1);
      ABORT: begin
        err_d   = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ack      = (state_q == IDLE && !reset && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
    req_done     = (state_q == DONE) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    req_err      = (state_q == DONE) && err_q;
    busy         = state_q != IDLE;
    si_tx_data   = (state_q != LOAD) ? 32'd0 :
                   (idx_q == 2'd0) ? data_q[95:64] : (idx_q == 2'd1) ? data_q[63:32] : data_q[31:0];
    si_tx_wmask  = (state_q == LOAD) ? 3'b001 << idx_q : 3'b000;
    si_tx_length = (state_q != IDLE && nw_q != 2'd0) ? len_q : 7'd0;
    si_tx_start  = state_q == START;
    si_tx_reset  = state_q == ABORT;
  end
endmodule

// File: tb/tb_si_tx_arbiter.sv
// tb_si_tx_arbiter: directed checks of si_tx_arbiter with fixed priority (u_a) and round-robin (u_b).
module tb_si_tx_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] req_valid;
  logic [95:0] d0, d1;
  logic [6:0] l0, l1;
  logic tx_busy;
  logic [1:0] ack_a, done_a, ack_b, done_b;
  logic err_a, busy_a, start_a, txr_a, err_b, busy_b, start_b, txr_b;
  logic [31:0] dat_a, dat_b;
  logic [2:0] wm_a, wm_b;
  logic [6:0] len_a, len_b;
  int n_cmp = 0, n_err = 0;

  si_tx_arbiter #(.HW_PRIORITY(1), .BUSY_WAIT(8), .TX_TIMEOUT(64)) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data0(d0), .req_data1(d1),
    .req_length0(l0), .req_length1(l1), .req_ack(ack_a), .req_done(done_a), .req_err(err_a),
    .busy(busy_a), .si_tx_data(dat_a), .si_tx_wmask(wm_a), .si_tx_length(len_a),
    .si_tx_start(start_a), .si_tx_reset(txr_a), .si_tx_busy(tx_busy));

  si_tx_arbiter #(.HW_PRIORITY(0), .BUSY_WAIT(8), .TX_TIMEOUT(64)) u_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data0(d0), .req_data1(d1),
    .req_length0(l0), .req_length1(l1), .req_ack(ack_b), .req_done(done_b), .req_err(err_b),
    .busy(busy_b), .si_tx_data(dat_b), .si_tx_wmask(wm_b), .si_tx_length(len_b),
    .si_tx_start(start_b), .si_tx_reset(txr_b), .si_tx_busy(tx_busy));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic early;
    int bad [2];
    int exp_rr [4];
    int got_rr [$];
    bad = '{0, 100};
    exp_rr = '{1, 0, 1, 0};
    req_valid = 2'b11; d0 = '0; d1 = '0; l0 = '0; l1 = '0; tx_busy = 1'b0;
    cyc(2);
    chk("rst_ack", ack_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_outs", {dat_a, wm_a, len_a, start_a, txr_a, done_a, err_a}, 0);
    req_valid = 2'b00; reset = 1'b0;
    cyc(1);
    // port 1 alone, one word
    d1 = {32'hA1B2C3D4, 32'h11111111, 32'h22222222}; l1 = 7'd24; req_valid = 2'b10; #1;
    chk("t1_ack", ack_a, 2'b10);
    cyc(1); req_valid = 2'b00; #1;
    chk("t1_busy", busy_a, 1);
    chk("t1_ack_off", ack_a, 0);
    cyc(1);
    chk("t1_load", {wm_a, dat_a}, {3'b001, 32'hA1B2C3D4});
    chk("t1_len", len_a, 24);
    cyc(1);
    chk("t1_start", {start_a, wm_a}, {1'b1, 3'b000});
    cyc(1); tx_busy = 1'b1;
    cyc(20); tx_busy = 1'b0; #1;
    chk("t1_nodone", done_a, 0);
    cyc(1);
    chk("t1_done", {done_a, err_a, len_a}, {2'b10, 1'b0, 7'd24});
    cyc(1);
    chk("t1_idle", {busy_a, done_a}, 0);
    // simultaneous requests, fixed priority, three words
    d0 = {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF}; l0 = 7'd96; l1 = 7'd96; req_valid = 2'b11; #1;
    chk("t2_ack", ack_a, 2'b01);
    cyc(1); req_valid = 2'b10;
    cyc(1); chk("t2_w0", {wm_a, dat_a}, {3'b001, 32'h01234567});
    cyc(1); chk("t2_w1", {wm_a, dat_a}, {3'b010, 32'h89ABCDEF});
    cyc(1); chk("t2_w2", {wm_a, dat_a}, {3'b100, 32'hDEADBEEF});
    cyc(1); chk("t2_start", {start_a, wm_a}, {1'b1, 3'b000});
    cyc(1); tx_busy = 1'b1;
    cyc(1); tx_busy = 1'b0;
    cyc(1); chk("t2_done", {done_a, err_a, ack_a}, {2'b01, 1'b0, 2'b00});
    cyc(1); chk("t2_ack1", ack_a, 2'b10);
    req_valid = 2'b00;
    rst_pulse();
    // illegal lengths are rejected without SI activity
    for (int i = 0; i < 2; i++) begin
      l0 = 7'(bad[i]); req_valid = 2'b01; #1;
      chk($sformatf("t3_ack_%0d", bad[i]), ack_a, 2'b01);
      cyc(1); req_valid = 2'b00; #1;
      chk($sformatf("t3_chk_%0d", bad[i]), {wm_a, start_a, txr_a}, 0);
      cyc(1);
      chk($sformatf("t3_done_%0d", bad[i]), {done_a, err_a}, {2'b01, 1'b1});
      chk($sformatf("t3_quiet_%0d", bad[i]), {wm_a, start_a, txr_a, len_a}, 0);
      cyc(1);
    end
    // busy never rises
    l0 = 7'd8; req_valid = 2'b01; #1;
    cyc(1); req_valid = 2'b00;
    cyc(2);
    chk("t4_start", start_a, 1);
    early = 1'b0;
    repeat (7) begin cyc(1); early |= txr_a; end
    chk("t4_early", early, 0);
    cyc(1); chk("t4_txreset", txr_a, 1);
    cyc(1); chk("t4_done", {done_a, err_a, txr_a}, {2'b01, 1'b1, 1'b0});
    cyc(1);
    // busy stuck high
    tx_busy = 1'b1; req_valid = 2'b01; #1;
    cyc(1); req_valid = 2'b00;
    cyc(2);
    chk("t5_start", start_a, 1);
    cyc(1);
    early = 1'b0;
    repeat (63) begin cyc(1); early |= txr_a; end
    chk("t5_early", early, 0);
    cyc(1); chk("t5_txreset", txr_a, 1);
    cyc(1); chk("t5_done", {done_a, err_a}, {2'b01, 1'b1});
    tx_busy = 1'b0;
    cyc(1);
    // round-robin with both ports held valid
    rst_pulse();
    l0 = 7'd8; l1 = 7'd8; req_valid = 2'b11; #1;
    chk("t6_hw", ack_a, 2'b01);
    for (int c = 0; c < 400 && got_rr.size() < 4; c++) begin
      if (ack_b != 2'b00) got_rr.push_back(int'(ack_b[1]));
      cyc(1); #1;
    end
    chk("t6_count", got_rr.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t6_rr%0d", i), (i < got_rr.size()) ? got_rr[i] : 2, exp_rr[i]);
    req_valid = 2'b00;
    rst_pulse();
    // reset while waiting for transmission to finish
    req_valid = 2'b01; #1;
    chk("t7_ack", ack_a, 2'b01);
    cyc(1); req_valid = 2'b10;
    cyc(2);
    cyc(1); tx_busy = 1'b1;
    cyc(1); chk("t7_waitdone", {busy_a, start_a}, {1'b1, 1'b0});
    #2; reset = 1'b1; #1;
    chk("t7_async", {ack_a, busy_a, done_a, err_a, dat_a, wm_a, len_a, start_a, txr_a}, 0);
    early = 1'b0;
    repeat (2) begin cyc(1); early |= (|done_a) | txr_a; end
    chk("t7_nodone", early, 0);
    reset = 1'b0; tx_busy = 1'b0; #1;
    chk("t7_reack", ack_a, 2'b10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
